// File: rtl/tone_gen.sv
// Speaker tone generator: per-colour square-wave pitch plus a fixed-length
// low-pitched error buzz that overrides lamp tones. Runs on the game clock.
module tone_gen #(
    parameter int unsigned HALF0    = 12,
    parameter int unsigned HALF1    = 16,
    parameter int unsigned HALF2    = 20,
    parameter int unsigned HALF3    = 24,
    parameter int unsigned ERR_HALF = 119,
    parameter int unsigned ERR_LEN  = 15000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LEN_W    = 14
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] TONE_SEL,
    input  logic       TONE_ENA,
    input  logic       ERR_STB,
    input  logic       MUTE,
    output logic       SPK,
    output logic       BUSY
);

    // Terminal counts are stored minus one so a half-period of 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] H0_M1   = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] H1_M1   = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] H2_M1   = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] H3_M1   = CNT_W'(HALF3 - 1);
    localparam logic [CNT_W-1:0] HERR_M1 = CNT_W'(ERR_HALF - 1);
    localparam logic [LEN_W-1:0] LEN_M1  = LEN_W'(ERR_LEN - 1);

    typedef enum logic [1:0] {StIdle, StTone, StError} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic             spk_q, spk_d;
    logic             spk_out_q;

    logic [CNT_W-1:0] tone_max;
    logic [CNT_W-1:0] active_max;
    logic             half_done;

    // Select the terminal half-period count for the current pitch.
    always_comb begin
        tone_max = H0_M1;
        case (cur_sel_q)
            2'd0:    tone_max = H0_M1;
            2'd1:    tone_max = H1_M1;
            2'd2:    tone_max = H2_M1;
            default: tone_max = H3_M1;
        endcase
        active_max = (state_q == StError) ? HERR_M1 : tone_max;
        half_done  = (half_cnt_q == active_max);
    end

    // Next-state logic: error strobe wins over every state rule.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        len_cnt_d  = len_cnt_q;
        cur_sel_d  = cur_sel_q;
        spk_d      = spk_q;

        if (ERR_STB) begin
            state_d    = StError;
            half_cnt_d = '0;
            len_cnt_d  = '0;
            spk_d      = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    spk_d      = 1'b0;
                    half_cnt_d = '0;
                    if (TONE_ENA) begin
                        state_d   = StTone;
                        cur_sel_d = TONE_SEL;
                    end
                end
                StTone: begin
                    if (!TONE_ENA) begin
                        state_d    = StIdle;
                        spk_d      = 1'b0;
                        half_cnt_d = '0;
                    end else if (TONE_SEL != cur_sel_q) begin
                        // New pitch is timed from this edge; keep current level.
                        cur_sel_d  = TONE_SEL;
                        half_cnt_d = '0;
                    end else if (half_done) begin
                        spk_d      = ~spk_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + CNT_W'(1);
                    end
                end
                StError: begin
                    if (len_cnt_q == LEN_M1) begin
                        state_d    = StIdle;
                        spk_d      = 1'b0;
                        half_cnt_d = '0;
                        len_cnt_d  = '0;
                    end else begin
                        len_cnt_d = len_cnt_q + LEN_W'(1);
                        if (half_done) begin
                            spk_d      = ~spk_q;
                            half_cnt_d = '0;
                        end else begin
                            half_cnt_d = half_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    spk_d      = 1'b0;
                    half_cnt_d = '0;
                    len_cnt_d  = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset; output gated by MUTE one edge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            half_cnt_q <= '0;
            len_cnt_q  <= '0;
            cur_sel_q  <= 2'd0;
            spk_q      <= 1'b0;
            spk_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            len_cnt_q  <= len_cnt_d;
            cur_sel_q  <= cur_sel_d;
            spk_q      <= spk_d;
            spk_out_q  <= spk_d & ~MUTE;
        end
    end

    assign SPK  = spk_out_q;
    assign BUSY = (state_q == StError);

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: stimulus queues expected SPK/BUSY per cycle,
// a negedge monitor pops and compares.
module tb_tone_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] TONE_SEL = 2'd0;
    logic       TONE_ENA = 1'b0;
    logic       ERR_STB = 1'b0;
    logic       MUTE = 1'b0;
    logic       SPK;
    logic       BUSY;

    tone_gen dut (
        .CLK      (CLK),
        .RST      (RST),
        .TONE_SEL (TONE_SEL),
        .TONE_ENA (TONE_ENA),
        .ERR_STB  (ERR_STB),
        .MUTE     (MUTE),
        .SPK      (SPK),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        logic  spk;
        logic  busy;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;

    // Expected level after edge k of a square wave with half-period h, starting low.
    function automatic logic phase(int k, int h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic void expect_at(int c, logic spk, logic busy, string name);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.spk  = spk;
        e.busy = busy;
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endfunction

    // Monitor: compare every expectation due at this cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_total++;
            if (mon_e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (SPK !== mon_e.spk || BUSY !== mon_e.busy) begin
                $display("FAIL %s @cyc %0d: got SPK=%b BUSY=%b, want SPK=%b BUSY=%b",
                         mon_e.name, cyc, SPK, BUSY, mon_e.spk, mon_e.busy);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int c;
        int s;
        int x;
        int y;
        int z;
        int r;

        // Reset
        wait_until(3);
        RST = 1'b0;
        expect_at(cyc, 1'b0, 1'b0, "reset");

        // Colour 0: half-period 12
        TONE_SEL = 2'd0;
        TONE_ENA = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < 100; k++) expect_at(e + k, phase(k, 12), 1'b0, "tone0");
        wait_until(e + 99);

        // Pitch change 0 -> 3 mid-note: counter restarts, level held
        TONE_SEL = 2'd3;
        c = cyc + 1;
        for (int k = 0; k < 100; k++) expect_at(c + k, phase(k, 24), 1'b0, "tone3");
        wait_until(c + 99);

        // Colour 2 tone, then error strobe while SPK is high
        TONE_SEL = 2'd2;
        s = cyc + 1;
        for (int j = 0; j < 30; j++) expect_at(s + j, phase(j, 20), 1'b0, "tone2");
        wait_until(s + 29);
        ERR_STB = 1'b1;
        x = cyc + 1;
        expect_at(x,         1'b0, 1'b1, "err_enter");
        expect_at(x + 1,     1'b0, 1'b1, "err_k1");
        expect_at(x + 118,   1'b0, 1'b1, "err_k118");
        expect_at(x + 119,   1'b1, 1'b1, "err_k119");
        expect_at(x + 237,   1'b1, 1'b1, "err_k237");
        expect_at(x + 238,   1'b0, 1'b1, "err_k238");
        expect_at(x + 357,   1'b1, 1'b1, "err_k357");
        expect_at(x + 14999, phase(14999, 119), 1'b1, "err_last");
        expect_at(x + 15000, 1'b0, 1'b0, "err_exit");
        for (int j = 0; j < 46; j++)
            expect_at(x + 15001 + j, phase(j, 20), 1'b0, "tone_resume");
        wait_until(x);
        ERR_STB = 1'b0;
        wait_until(x + 15001 + 45);

        // Re-strobe at cycle 10000 of a buzz extends it to 25000 total
        TONE_ENA = 1'b0;
        wait_until(cyc + 2);
        ERR_STB = 1'b1;
        y = cyc + 1;
        z = y + 10000;
        expect_at(y,         1'b0, 1'b1, "buzz2_enter");
        expect_at(y + 119,   1'b1, 1'b1, "buzz2_k119");
        expect_at(y + 9999,  phase(9999, 119), 1'b1, "buzz2_pre");
        expect_at(z,         1'b0, 1'b1, "restart");
        expect_at(z + 119,   1'b1, 1'b1, "restart_k119");
        expect_at(y + 15000, phase(5000, 119), 1'b1, "no_early_end");
        expect_at(y + 24999, phase(14999, 119), 1'b1, "buzz2_last");
        expect_at(y + 25000, 1'b0, 1'b0, "buzz2_exit");
        wait_until(y);
        ERR_STB = 1'b0;
        wait_until(y + 9999);
        ERR_STB = 1'b1;
        wait_until(z);
        ERR_STB = 1'b0;
        wait_until(y + 25000);

        // Mute during colour 1 tone (half-period 16)
        TONE_SEL = 2'd1;
        TONE_ENA = 1'b1;
        e = cyc + 1;
        expect_at(e,      1'b0, 1'b0, "mute_pre0");
        expect_at(e + 15, 1'b0, 1'b0, "mute_pre15");
        expect_at(e + 16, 1'b1, 1'b0, "mute_pre16");
        expect_at(e + 19, 1'b1, 1'b0, "mute_pre19");
        expect_at(e + 20, 1'b0, 1'b0, "muted20");
        expect_at(e + 30, 1'b0, 1'b0, "muted30");
        expect_at(e + 49, 1'b0, 1'b0, "muted49");
        expect_at(e + 50, 1'b1, 1'b0, "unmute50");
        expect_at(e + 63, 1'b1, 1'b0, "unmute63");
        expect_at(e + 64, 1'b0, 1'b0, "unmute64");
        wait_until(e + 19);
        MUTE = 1'b1;
        wait_until(e + 49);
        MUTE = 1'b0;
        wait_until(e + 64);

        // Reset mid-buzz, then fresh colour 0 tone
        TONE_SEL = 2'd0;
        ERR_STB = 1'b1;
        x = cyc + 1;
        r = x + 150;
        expect_at(x + 149, 1'b1, 1'b1, "pre_reset");
        expect_at(r,       1'b0, 1'b0, "mid_reset");
        expect_at(r + 1,   1'b0, 1'b0, "post_reset_j0");
        expect_at(r + 12,  1'b0, 1'b0, "post_reset_j11");
        expect_at(r + 13,  1'b1, 1'b0, "post_reset_j12");
        expect_at(r + 24,  1'b1, 1'b0, "post_reset_j23");
        expect_at(r + 25,  1'b0, 1'b0, "post_reset_j24");
        wait_until(x);
        ERR_STB = 1'b0;
        wait_until(x + 149);
        RST = 1'b1;
        wait_until(r);
        RST = 1'b0;
        wait_until(r + 31);

        wait_until(cyc + 2);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Speaker driver downstream of the Simon controller, on the 10 kHz game clock.
- Consumes the controller's lamp code/enable and produces a square wave on the spare output pin (uo_out[4]).
- Each lamp colour gets its own pitch.
- A strobe from the controller starts a fixed-length, low-pitched error buzz that overrides lamp tones.

Parameters:
- HALF0, 12, half-period in CLK cycles for colour 0 (~415 Hz at 10 kHz)
- HALF1, 16, half-period for colour 1 (~310 Hz)
- HALF2, 20, half-period for colour 2 (~250 Hz)
- HALF3, 24, half-period for colour 3 (~208 Hz)
- ERR_HALF, 119, half-period of error buzz (~42 Hz)
- ERR_LEN, 15000, error buzz duration in CLK cycles (1.5 s)
- CNT_W, 8, width of half-period counter; all HALFx/ERR_HALF in 1..2^CNT_W
- LEN_W, 14, width of error length counter; ERR_LEN in 1..2^LEN_W

Ports:
- CLK  in  1  game clock (10 kHz divided clock)
- RST  in  1  synchronous reset, active-high
- TONE_SEL  in  2  colour code from controller lamp output
- TONE_ENA  in  1  lamp enable; high = play TONE_SEL pitch
- ERR_STB  in  1  single-cycle pulse: start error buzz
- MUTE  in  1  force speaker low; internal counting continues
- SPK  out  1  registered square-wave speaker drive
- BUSY  out  1  high while error buzz is active

Behaviour:
- All state is registered on CLK rising edge. Reset is synchronous: with RST high at an edge, state=IDLE, half_cnt=0, len_cnt=0, SPK=0, BUSY=0. Reset mid-tone or mid-buzz aborts immediately.
- States: IDLE, TONE, ERROR. Priority at each edge: RST > ERR_STB > state rules.
- IDLE:
  - ERR_STB=1 -> ERROR, half_cnt=0, len_cnt=0, SPK=0, BUSY=1.
  - Else TONE_ENA=1 -> TONE, half_cnt=0, SPK=0, latch cur_sel=TONE_SEL.
  - Else stay; SPK=0.
- TONE, active half-period H = HALFx selected by cur_sel:
  - Each edge: if half_cnt==H-1, toggle spk_q and clear half_cnt; else half_cnt+1.
  - The first toggle (SPK 0->1) occurs H edges after the entry edge. Period is exactly 2*H cycles; duty is 50%.
  - TONE_SEL != cur_sel while TONE_ENA=1: latch new cur_sel, clear half_cnt, spk_q unchanged. The new pitch is measured from that edge.
  - TONE_ENA=0 -> IDLE, spk_q=0, half_cnt=0 at that edge.
  - ERR_STB=1 -> ERROR, as from IDLE.
- ERROR, H = ERR_HALF:
  - Toggling uses the same rule as TONE. len_cnt increments every edge.
  - When len_cnt==ERR_LEN-1: -> IDLE, spk_q=0, BUSY=0. BUSY is high for exactly ERR_LEN cycles.
  - ERR_STB=1 while in ERROR restarts: len_cnt=0, half_cnt=0, spk_q=0.
  - TONE_ENA/TONE_SEL are ignored in ERROR. Exit is always to IDLE; a still-high TONE_ENA enters TONE on the following edge.
- MUTE: SPK = spk_q & ~MUTE. The gating is registered, so SPK reflects MUTE one edge after it is sampled. State, counters and BUSY are unaffected by MUTE.
- Counters never exceed H-1 / ERR_LEN-1. No wrap-around path exists for legal parameters.
- Latency: TONE_ENA rising -> first SPK edge = HALFx+1 edges. ERR_STB -> BUSY high after 1 edge.

Test Plan:
- Reset then TONE_ENA=1, TONE_SEL=0 for 100 cycles -> SPK low 12 cycles after entry edge, then alternates 12 high / 12 low; period 24.
- TONE_SEL 0->3 mid-note while enabled -> half_cnt restarts, SPK holds level 24 cycles, then toggles with period 48.
- ERR_STB pulse during TONE_SEL=2 tone -> BUSY=1 next edge, SPK=0, then period 238. BUSY falls after exactly 15000 cycles, SPK=0. With TONE_ENA still high, TONE resumes one edge later.
- Second ERR_STB at cycle 10000 of a buzz -> BUSY stays high 15000 further cycles (25000 total).
- MUTE=1 during tone -> SPK=0 from next edge. Release MUTE -> SPK resumes in phase with the unmuted counter.
- RST=1 mid-ERROR at an edge -> SPK=0, BUSY=0, IDLE. With TONE_ENA=1 after release, the tone starts with a fresh counter.
